// File: rtl/ray_sample_collector.sv
// Tags MLP-stage RGB/sigma samples with ray/sample position and buffers them in a first-word-fall-through FIFO.
// Optional NaN sigma filtering is enabled by defining RAY_SAMPLE_COLLECTOR_NAN_FILTER_EN.
module ray_sample_collector #(
  parameter int unsigned IN_WIDTH        = 32,
  parameter int unsigned OUT_DIM         = 4,
  parameter int unsigned SAMPLES_PER_RAY = 64,
  parameter int unsigned RAY_CNT         = 1024,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             start,
  output logic                                             busy,
  output logic                                             done,
  input  logic [OUT_DIM*IN_WIDTH-1:0]                      in_rgb_sigma,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  output logic [OUT_DIM*IN_WIDTH-1:0]                      out_rgb_sigma,
  output logic [$clog2(SAMPLES_PER_RAY)-1:0]               out_sample_idx,
  output logic [((RAY_CNT > 1) ? $clog2(RAY_CNT) : 1)-1:0] out_ray_idx,
  output logic                                             out_last,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [15:0]                                      nan_count
);

  localparam int unsigned DW     = OUT_DIM * IN_WIDTH;
  localparam int unsigned SW     = $clog2(SAMPLES_PER_RAY);
  localparam int unsigned RW     = (RAY_CNT > 1) ? $clog2(RAY_CNT) : 1;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned SIG_LO = 3 * IN_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] sidx;
    logic [RW-1:0] ridx;
    logic          last;
  } entry_t;

  state_t        state;
  entry_t        mem [FIFO_DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [SW-1:0] sample_idx;
  logic [RW-1:0] ray_idx;
  logic          push;
  logic          pop;
  logic          ray_end;
  logic          job_end;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign ray_end  = (sample_idx == SW'(SAMPLES_PER_RAY - 1));
  assign job_end  = ray_end && (ray_idx == RW'(RAY_CNT - 1));
  assign count_nx = count + CW'(push) - CW'(pop);

`ifdef RAY_SAMPLE_COLLECTOR_NAN_FILTER_EN
  logic sigma_nan;
  assign sigma_nan = (in_rgb_sigma[SIG_LO+23 +: 8] == 8'hFF) &&
                     (in_rgb_sigma[SIG_LO +: 23] != 23'd0);
`endif

  // FIFO write payload, with NaN sigma squashed to +0.0 when filtering is built in
  always_comb begin
    wr_entry.data = in_rgb_sigma;
    wr_entry.sidx = sample_idx;
    wr_entry.ridx = ray_idx;
    wr_entry.last = ray_end;
`ifdef RAY_SAMPLE_COLLECTOR_NAN_FILTER_EN
    if (sigma_nan) begin
      wr_entry.data[SIG_LO +: IN_WIDTH] = '0;
    end
`endif
  end

  assign head           = mem[rd_ptr];
  assign out_rgb_sigma  = head.data;
  assign out_sample_idx = head.sidx;
  assign out_ray_idx    = head.ridx;
  assign out_last       = head.last;

  // Job FSM, position counters and FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sample_idx <= '0;
      ray_idx    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      count     <= count_nx;
      out_valid <= (count_nx != '0);
      done      <= 1'b0;

      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + AW'(1);
        if (ray_end) begin
          sample_idx <= '0;
          ray_idx    <= ray_idx + RW'(1);
        end else begin
          sample_idx <= sample_idx + SW'(1);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case (state)
        S_IDLE: begin
          in_ready <= 1'b0;
          if (start) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
            sample_idx <= '0;
            ray_idx    <= '0;
          end
        end
        S_RUN: begin
          if (push && job_end) begin
            state    <= S_DRAIN;
            in_ready <= 1'b0;
          end else begin
            in_ready <= (count_nx != CW'(FIFO_DEPTH));
          end
        end
        S_DRAIN: begin
          in_ready <= 1'b0;
          if (count == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          in_ready <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RAY_SAMPLE_COLLECTOR_NAN_FILTER_EN
  // Saturating count of filtered samples for the current job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_count <= '0;
    end else if (state == S_IDLE && start) begin
      nan_count <= '0;
    end else if (push && sigma_nan && nan_count != 16'hFFFF) begin
      nan_count <= nan_count + 16'd1;
    end
  end
`else
  assign nan_count = 16'h0000;
`endif

endmodule
